// File: rtl/qbert_input_pkg.sv
// Shared definitions for the Q*bert-family input conditioning blocks.
package qbert_input_pkg;

  localparam int SPIN_FRAC_BITS = 3;
  localparam int SPIN_ACC_W     = 11;
  localparam logic [1:0] INIT_LAST = 2'd2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } spin_state_t;

  // Sign-extend a spinner delta to accumulator width and scale by 2^-sens.
  function automatic logic [SPIN_ACC_W-1:0] scale_delta(input logic [7:0] d,
                                                        input logic [1:0] sens);
    logic [SPIN_ACC_W-1:0] sx;
    logic [1:0]            sh;
    sx = {{(SPIN_ACC_W-8){d[7]}}, d};
    sh = 2'(SPIN_FRAC_BITS) - sens;
    return sx << sh;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a toggle-encoded event flag, with edge detect.
// While load_ref_i is high the reference tracks the input but no event is reported.
module toggle_sync (
  input  logic clk_sys,
  input  logic reset,
  input  logic d_i,
  input  logic load_ref_i,
  output logic event_o
);

  logic [1:0] sync_q;
  logic       ref_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      ref_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      ref_q  <= sync_q[1];
    end
  end

  assign event_o = (sync_q[1] ^ ref_q) & ~load_ref_i;

endmodule

// File: rtl/spinner_accum.sv
// Accumulates spinner deltas and digital spin ticks into an absolute dial position.
// state | meaning
// INIT  | 3 cycles after reset: edge reference absorbs the current toggle level
// RUN   | captures and ticks update the accumulator
module spinner_accum
  import qbert_input_pkg::*;
#(
  parameter int RATE_DIV     = 20000,
  parameter int DIGITAL_STEP = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [8:0] spinner,
  input  logic       joy_left,
  input  logic       joy_right,
  input  logic [1:0] sens,
  output logic [7:0] position,
  output logic       moved
);

  localparam int CNT_W = $clog2(RATE_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(RATE_DIV - 1);
  localparam logic [SPIN_ACC_W-1:0] DIG_INC  = SPIN_ACC_W'(DIGITAL_STEP << SPIN_FRAC_BITS);

  spin_state_t state_q, state_d;
  logic [1:0]  init_cnt_q, init_cnt_d;
  logic        load_ref;
  logic        run;

  logic        spin_evt;
  logic        cap_vld_q, cap_vld_d;
  logic [7:0]  cap_data_q, cap_data_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dig_active;
  logic             tick;

  logic [SPIN_ACC_W-1:0] acc_q, acc_d;
  logic [SPIN_ACC_W-1:0] spin_inc, dig_inc;
  logic                  moved_q, moved_d;

  toggle_sync u_toggle_sync (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .d_i       (spinner[8]),
    .load_ref_i(load_ref),
    .event_o   (spin_evt)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    load_ref   = 1'b0;
    run        = 1'b0;
    case (state_q)
      INIT: begin
        load_ref = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      RUN: run = 1'b1;
      default: state_d = INIT;
    endcase
  end

  // Delta data is stable long after the toggle, so it is captured unsynchronised.
  always_comb begin
    cap_vld_d  = run & spin_evt;
    cap_data_d = cap_data_q;
    if (cap_vld_d) cap_data_d = spinner[7:0];
  end

  always_comb begin
    dig_active = run & (joy_left ^ joy_right);
    tick       = dig_active && (cnt_q == CNT_LAST);
    cnt_d      = '0;
    if (dig_active && !tick) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    spin_inc = cap_vld_q ? scale_delta(cap_data_q, sens) : '0;
    dig_inc  = '0;
    if (tick) dig_inc = joy_right ? DIG_INC : -DIG_INC;
    acc_d    = acc_q + spin_inc + dig_inc;
    moved_d  = acc_d[SPIN_ACC_W-1:SPIN_FRAC_BITS] != acc_q[SPIN_ACC_W-1:SPIN_FRAC_BITS];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cap_vld_q  <= 1'b0;
      cap_data_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      moved_q    <= 1'b0;
    end else begin
      cap_vld_q  <= cap_vld_d;
      cap_data_q <= cap_data_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      moved_q    <= moved_d;
    end
  end

  assign position = acc_q[SPIN_ACC_W-1:SPIN_FRAC_BITS];
  assign moved    = moved_q;

endmodule

// File: tb/tb_spinner_accum.sv
// Directed bench for spinner_accum with a fast digital spin rate.
module tb_spinner_accum;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [8:0] spinner;
  logic       joy_left, joy_right;
  logic [1:0] sens;
  logic [7:0] position;
  logic       moved;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] cur_pos;

  spinner_accum #(.RATE_DIV(4), .DIGITAL_STEP(2)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .spinner  (spinner),
    .joy_left (joy_left),
    .joy_right(joy_right),
    .sens     (sens),
    .position (position),
    .moved    (moved)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggle the report flag with a new delta; position must hold until edge N+3.
  task automatic send_delta(input logic [7:0] d, input logic [7:0] exp_pos,
                            input logic exp_mv, input string tag);
    spinner = {~spinner[8], d};
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_val({tag, "_lat"}, position, cur_pos);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_val({tag, "_pos"}, position, exp_pos);
    check_val({tag, "_mv"}, moved, exp_mv);
    cur_pos = exp_pos;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_val({tag, "_mv_clr"}, moved, 1'b0);
  endtask

  task automatic step_check(input string tag, input logic [7:0] exp_pos, input logic exp_mv);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_val({tag, "_pos"}, position, exp_pos);
    check_val({tag, "_mv"}, moved, exp_mv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; spinner = '0; joy_left = 0; joy_right = 0; sens = 2'd0;
    cur_pos = 8'd0;
    #3;
    check_val("rst_pos", position, 8'd0);
    check_val("rst_mv", moved, 1'b0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    check_val("init_pos", position, 8'd0);

    send_delta(8'h05, 8'd5, 1'b1, "plus5");
    send_delta(8'hF9, 8'd254, 1'b1, "minus7");
    send_delta(8'h01, 8'd255, 1'b1, "to255");
    send_delta(8'h01, 8'd0, 1'b1, "wrap0");
    send_delta(8'h00, 8'd0, 1'b0, "zero");

    sens = 2'd3;
    for (int i = 0; i < 7; i++) send_delta(8'h01, 8'd0, 1'b0, "frac");
    send_delta(8'h01, 8'd1, 1'b1, "frac8");

    // Right held: ticks at the 4th, 8th and 12th edge after the press.
    joy_right = 1'b1;
    for (int i = 1; i <= 12; i++)
      step_check("right", 8'(1 + 2 * (i / 4)), (i % 4) == 0);
    joy_right = 1'b0;
    cur_pos = 8'd7;

    joy_left = 1'b1; joy_right = 1'b1;
    for (int i = 0; i < 10; i++) step_check("both", 8'd7, 1'b0);
    // Counter must have been held at 0: first tick exactly 4 edges after release of left.
    joy_left = 1'b0;
    step_check("held1", 8'd7, 1'b0);
    step_check("held2", 8'd7, 1'b0);
    step_check("held3", 8'd7, 1'b0);
    step_check("held4", 8'd9, 1'b1);
    joy_right = 1'b0;

    sens = 2'd0;
    joy_left = 1'b1;
    spinner = {~spinner[8], 8'h03};
    step_check("sim1", 8'd9, 1'b0);
    step_check("sim2", 8'd9, 1'b0);
    step_check("sim3", 8'd9, 1'b0);
    step_check("sim4", 8'd10, 1'b1);
    joy_left = 1'b0;
    step_check("sim5", 8'd10, 1'b0);
    cur_pos = 8'd10;

    send_delta(8'h76, 8'h80, 1'b1, "to80");
    @(posedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_pos", position, 8'd0);
    check_val("arst_mv", moved, 1'b0);
    spinner = {1'b1, 8'h33};
    @(negedge clk_sys);
    reset = 1'b0;
    cur_pos = 8'd0;
    for (int i = 0; i < 8; i++) step_check("absorb", 8'd0, 1'b0);
    send_delta(8'h04, 8'd4, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
